// File: rtl/renkon_ctrl_sink_if.sv
`default_nettype none
// ctrl_bus: three-wire frame handshake (start / valid / stop) between a pixel producer and a sink.
interface ctrl_bus;
  logic start;
  logic valid;
  logic stop;

  modport master (output start, output valid, output stop);
  modport slave  (input  start, input  valid, input  stop);
endinterface
`default_nettype wire

// File: rtl/renkon_ctrl_sink.sv
`default_nettype none
// renkon_ctrl_sink: writes framed pixel streams into image memory, one flen-sized block per frame.
// Optional protocol checking and write clipping: define RENKON_SINK_CHECK_EN.
module renkon_ctrl_sink #(
  parameter int DWIDTH  = 16,
  parameter int LWIDTH  = 10,
  parameter int IMGSIZE = 12
) (
  input  logic                      clk,
  input  logic                      xrst,
  input  logic                      req,
  input  logic [IMGSIZE-1:0]        out_offset,
  input  logic [LWIDTH-1:0]         img_size,
  input  logic [LWIDTH-1:0]         fil_size,
  input  logic [LWIDTH-1:0]         total_out,
  ctrl_bus.slave                    in_ctrl,
  input  logic signed [DWIDTH-1:0]  in_data,
  output logic                      ack,
  output logic                      mem_we,
  output logic [IMGSIZE-1:0]        mem_addr,
  output logic signed [DWIDTH-1:0]  mem_wdata,
  output logic [LWIDTH-1:0]         frame_cnt,
  output logic                      frame_err
);

  localparam int FW = 2 * LWIDTH;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RECV = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]               state_q, state_d;
  logic [LWIDTH-1:0]        total_q;
  logic [FW-1:0]            flen_q;
  logic [LWIDTH-1:0]        frame_cnt_q, frame_cnt_d;
  logic [FW-1:0]            beat_idx_q, beat_idx_d;
  logic [IMGSIZE-1:0]       base_q, base_d;
  logic                     ack_q;
  logic                     we_q;
  logic [IMGSIZE-1:0]       addr_q;
  logic signed [DWIDTH-1:0] wdata_q;

  logic [FW-1:0]            side;
  logic [LWIDTH:0]          cnt_inc;
  logic                     accept_req;
  logic                     in_recv;
  logic                     restart;
  logic                     beat;
  logic                     stop_evt;
  logic                     last_frame;
  logic                     do_write;

  assign side       = FW'(img_size) - FW'(fil_size) + FW'(1);
  assign accept_req = (state_q == S_IDLE) && req;
  assign in_recv    = (state_q == S_RECV);
  // A start seen mid-frame restarts the frame; that cycle carries no data.
  assign restart    = in_recv && in_ctrl.start;
  assign beat       = in_recv && in_ctrl.valid && !in_ctrl.start;
  assign stop_evt   = in_recv && in_ctrl.stop && !in_ctrl.start;
  assign cnt_inc    = {1'b0, frame_cnt_q} + (LWIDTH+1)'(1);
  assign last_frame = (cnt_inc >= {1'b0, total_q});

`ifdef RENKON_SINK_CHECK_EN
  logic          err_q;
  logic          overrun;
  logic          err_set;
  logic [FW-1:0] beats_at_stop;

  assign overrun       = beat && (beat_idx_q >= flen_q);
  assign beats_at_stop = beat_idx_q + FW'(beat);
  assign do_write      = beat && !overrun;
  assign err_set       = restart
                       || (((state_q == S_IDLE) || (state_q == S_WAIT)) && in_ctrl.valid)
                       || (stop_evt && (beats_at_stop != flen_q))
                       || overrun;

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      err_q <= 1'b0;
    end else if (accept_req) begin
      err_q <= 1'b0;
    end else if (err_set) begin
      err_q <= 1'b1;
    end
  end

  assign frame_err = err_q;
`else
  assign do_write  = beat;
  assign frame_err = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    beat_idx_d  = beat_idx_q;
    base_d      = base_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          state_d     = S_WAIT;
          frame_cnt_d = '0;
          beat_idx_d  = '0;
          base_d      = out_offset;
        end
      end
      S_WAIT: begin
        if (total_q == '0) begin
          state_d = S_DONE;
        end else if (in_ctrl.start) begin
          state_d    = S_RECV;
          beat_idx_d = '0;
        end
      end
      S_RECV: begin
        if (restart) begin
          beat_idx_d = '0;
        end else begin
          if (beat) begin
            beat_idx_d = beat_idx_q + FW'(1);
          end
          // Running base replaces out_offset + frame_cnt*flen.
          if (stop_evt) begin
            frame_cnt_d = frame_cnt_q + LWIDTH'(1);
            base_d      = base_q + IMGSIZE'(flen_q);
            state_d     = last_frame ? S_DONE : S_WAIT;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      state_q     <= S_IDLE;
      total_q     <= '0;
      flen_q      <= '0;
      frame_cnt_q <= '0;
      beat_idx_q  <= '0;
      base_q      <= '0;
      ack_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      beat_idx_q  <= beat_idx_d;
      base_q      <= base_d;
      if (accept_req) begin
        total_q <= total_out;
        flen_q  <= side * side;
      end
      we_q <= do_write;
      if (do_write) begin
        addr_q  <= base_q + IMGSIZE'(beat_idx_q);
        wdata_q <= in_data;
      end
      ack_q <= (state_q == S_DONE);
    end
  end

  assign ack       = ack_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign frame_cnt = frame_cnt_q;

endmodule
`default_nettype wire

// File: doc/renkon_ctrl_sink.md
RENKON_CTRL_SINK -- requirements
Module: renkon_ctrl_sink

Interface
REQ-001 SHALL take parameter DWIDTH, default 16: signed pixel width.
REQ-002 SHALL take parameter LWIDTH, default 10: layer-size field width.
REQ-003 SHALL take parameter IMGSIZE, default 12: image memory address width.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state on posedge clk.
REQ-005 SHALL have port xrst, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port req, input, 1 bit: single-cycle job request; latches the configuration inputs.
REQ-007 SHALL have port out_offset, input, IMGSIZE bits: base write address.
REQ-008 SHALL have ports img_size and fil_size, input, LWIDTH bits each: input side and filter side.
REQ-009 SHALL have port total_out, input, LWIDTH bits: number of frames per job.
REQ-010 SHALL have port in_ctrl, ctrl_bus slave, fields start/valid/stop at 1 bit each: upstream frame handshake.
REQ-011 SHALL have port in_data, input, signed DWIDTH bits: pixel qualified by in_ctrl.valid.
REQ-012 SHALL have port ack, output, 1 bit: job-complete pulse.
REQ-013 SHALL have ports mem_we (1 bit), mem_addr (IMGSIZE bits) and mem_wdata (signed DWIDTH bits), all outputs: image memory write port.
REQ-014 SHALL have port frame_cnt, output, LWIDTH bits: frames completed in the current job.
REQ-015 SHALL have port frame_err, output, 1 bit: sticky protocol error.

Function
REQ-016 SHALL implement FSM S_IDLE -> S_WAIT on req; S_WAIT -> S_RECV on in_ctrl.start; S_RECV -> S_WAIT on in_ctrl.stop while frame_cnt+1 < total_out; S_RECV -> S_DONE on the final stop; S_DONE -> S_IDLE after 1 cycle.
REQ-017 SHALL latch at req: out_offset; total_out; and flen = (img_size-fil_size+1)^2, computed at LWIDTH*2 bits.
REQ-018 SHALL count a beat on every cycle in S_RECV with in_ctrl.valid=1, including the stop cycle; start cycle carries no data.
REQ-019 SHALL register each beat's write: mem_we=1, mem_wdata=in_data, mem_addr=base+beat_idx, 1 cycle after the valid beat.
REQ-020 SHALL compute base = out_offset + frame_cnt*flen, held in a running register advanced by flen at each stop; no multiplier.
REQ-021 SHALL raise ack for exactly 1 cycle in S_DONE, which is the cycle after the final stop beat's write.
REQ-022 SHALL increment frame_cnt at each stop; clear it on req.
REQ-023 SHALL ignore req outside S_IDLE.
REQ-024 SHALL treat mem_addr overflow as wrapping modulo 2^IMGSIZE.
REQ-025 SHALL, when total_out=0, go S_WAIT -> S_DONE immediately and raise ack with no writes.

Reset
REQ-026 SHALL on xrst=0, asynchronously: state=S_IDLE; ack=0; mem_we=0; mem_addr=0; mem_wdata=0; frame_cnt=0; frame_err=0; all latched configuration=0.
REQ-027 SHALL on reset mid-frame drop the in-flight write; no write follows reset deassertion until a new req.

Configuration
REQ-028 SHALL, with macro RENKON_SINK_CHECK_EN defined, set frame_err on any of these: start in S_RECV (the frame restarts at the same base); valid in S_IDLE/S_WAIT (the beat is dropped); beat count != flen at stop; beat_idx >= flen (that write is suppressed).
REQ-029 SHALL clear frame_err on req.
REQ-030 SHALL, without RENKON_SINK_CHECK_EN, tie frame_err to 0, perform no clipping, and write every S_RECV valid beat.

Verification
REQ-031 SHALL cover: req with img_size=6, fil_size=3, total_out=3, out_offset=3000, then 3 frames of 16 valid beats (data 1..16) -> writes to addresses 3000..3047, frame_cnt=3, ack 1 cycle after the last write, frame_err=0.
REQ-032 SHALL cover: same job with a 15-beat second frame -> frame_err=1 at its stop; third frame base 3032.
REQ-033 SHALL cover: 17 beats in one frame with CHECK_EN -> 17th beat not written, frame_err=1; without CHECK_EN -> 17th beat written at 3016.
REQ-034 SHALL cover: xrst asserted at beat 8 of frame 2 -> all outputs 0 immediately; no mem_we after release until req.
REQ-035 SHALL cover: total_out=0 -> ack within 3 cycles of req, no mem_we.
REQ-036 SHALL cover: start reasserted mid-frame -> frame_err=1 and the frame rewrites from its own base.
